xm_stage_latch: RTL and testbench

Execute-to-memory pipeline register of the processor. It captures the execute-stage result (ALU output, including the arithmetic-right-shift path), the store operand, the destination register and the overflow flag, and presents them to the memory stage. On arithmetic overflow it rewrites the destination to the status register and replaces the result with the exception code. Stall, flush and valid tracking keep bubbles and squashed instructions from reaching memory or writeback.

---
 rtl/xm_stage_latch_if.sv | 44 ++++
 rtl/xm_stage_latch.sv | 100 ++++++++++
 tb/tb_xm_stage_latch.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/xm_stage_latch_if.sv
// Execute-to-memory boundary bundle: X-side instruction fields, pipeline
// control (stall/flush) and the registered M-side view.
interface xm_stage_latch_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              x_valid;
  logic [DATA_W-1:0] x_result;
  logic [DATA_W-1:0] x_store_data;
  logic [REG_W-1:0]  x_rd;
  logic              x_we;
  logic              x_is_store;
  logic              x_is_load;
  logic              x_ovf;
  logic [2:0]        x_exc_code;
  logic              stall;
  logic              flush;

  logic              m_valid;
  logic [DATA_W-1:0] m_result;
  logic [DATA_W-1:0] m_store_data;
  logic [REG_W-1:0]  m_rd;
  logic              m_we;
  logic              m_is_store;
  logic              m_is_load;
  logic              m_exc;
  logic [15:0]       exc_count;

  // Upstream side: drives the execute-stage fields and control, observes M.
  modport master (
    output x_valid, x_result, x_store_data, x_rd, x_we, x_is_store,
           x_is_load, x_ovf, x_exc_code, stall, flush,
    input  m_valid, m_result, m_store_data, m_rd, m_we, m_is_store,
           m_is_load, m_exc, exc_count
  );

  // Latch side: consumes the execute-stage fields, presents M.
  modport slave (
    input  x_valid, x_result, x_store_data, x_rd, x_we, x_is_store,
           x_is_load, x_ovf, x_exc_code, stall, flush,
    output m_valid, m_result, m_store_data, m_rd, m_we, m_is_store,
           m_is_load, m_exc, exc_count
  );
endinterface

// File: rtl/xm_stage_latch.sv
// Execute-to-memory pipeline register. Squashes bubbles/flushed ops, turns
// an overflowing arithmetic op into a write of its exception code to the
// status register, and keeps a saturating count of exceptions entering M.
module xm_stage_latch #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = 30
) (
  input  logic              clock,
  input  logic              reset_n,
  xm_stage_latch_if.slave   bus
);

  localparam logic [REG_W-1:0] STATUS_RD = REG_W'(STATUS_REG);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              w_vld_p0;
  logic              w_take_exc_p0;
  logic [DATA_W-1:0] w_result_p0;
  logic [DATA_W-1:0] w_store_p0;
  logic [REG_W-1:0]  w_rd_p0;
  logic              w_we_p0;
  logic              w_is_store_p0;
  logic              w_is_load_p0;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_result_p1;
  logic [DATA_W-1:0] r_store_p1;
  logic [REG_W-1:0]  r_rd_p1;
  logic              r_we_p1;
  logic              r_is_store_p1;
  logic              r_is_load_p1;
  logic              r_exc_p1;
  logic [15:0]       r_exc_count;

  // Next M-side contents: zeroed bubble, exception rewrite, or pass-through.
  always_comb begin
    w_vld_p0      = bus.x_valid & ~bus.flush;
    w_take_exc_p0 = w_vld_p0 & bus.x_ovf & (bus.x_exc_code != 3'd0);
    w_result_p0   = '0;
    w_store_p0    = '0;
    w_rd_p0       = '0;
    w_we_p0       = 1'b0;
    w_is_store_p0 = 1'b0;
    w_is_load_p0  = 1'b0;
    if (w_take_exc_p0) begin
      w_result_p0 = DATA_W'(bus.x_exc_code);
      w_store_p0  = bus.x_store_data;
      w_rd_p0     = STATUS_RD;
      w_we_p0     = 1'b1;
    end else if (w_vld_p0) begin
      w_result_p0   = bus.x_result;
      w_store_p0    = bus.x_store_data;
      w_rd_p0       = bus.x_rd;
      w_we_p0       = bus.x_we & (bus.x_rd != '0);
      w_is_store_p0 = bus.x_is_store;
      w_is_load_p0  = bus.x_is_load;
    end
  end

  // ---- X -> M stage boundary ----
  // Capture on every unstalled edge; stall freezes everything, flush included.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1      <= 1'b0;
      r_result_p1   <= '0;
      r_store_p1    <= '0;
      r_rd_p1       <= '0;
      r_we_p1       <= 1'b0;
      r_is_store_p1 <= 1'b0;
      r_is_load_p1  <= 1'b0;
      r_exc_p1      <= 1'b0;
      r_exc_count   <= '0;
    end else if (!bus.stall) begin
      r_vld_p1      <= w_vld_p0;
      r_result_p1   <= w_result_p0;
      r_store_p1    <= w_store_p0;
      r_rd_p1       <= w_rd_p0;
      r_we_p1       <= w_we_p0;
      r_is_store_p1 <= w_is_store_p0;
      r_is_load_p1  <= w_is_load_p0;
      r_exc_p1      <= w_take_exc_p0;
      if (w_take_exc_p0) r_exc_count <= sat_inc16(r_exc_count);
    end
  end

  assign bus.m_valid      = r_vld_p1;
  assign bus.m_result     = r_result_p1;
  assign bus.m_store_data = r_store_p1;
  assign bus.m_rd         = r_rd_p1;
  assign bus.m_we         = r_we_p1;
  assign bus.m_is_store   = r_is_store_p1;
  assign bus.m_is_load    = r_is_load_p1;
  assign bus.m_exc        = r_exc_p1;
  assign bus.exc_count    = r_exc_count;

endmodule

// File: tb/tb_xm_stage_latch.sv
// Directed scoreboard bench for xm_stage_latch: the driver pushes the
// hand-computed M-side state per edge, the monitor pops and compares.
module tb_xm_stage_latch;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        we;
    logic        is_store;
    logic        is_load;
    logic        ovf;
    logic [2:0]  code;
    logic        stall;
    logic        flush;
  } xin_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        we;
    logic        is_store;
    logic        is_load;
    logic        exc;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  xm_stage_latch_if #(.DATA_W(32), .REG_W(5)) bus ();

  xm_stage_latch #(.DATA_W(32), .REG_W(5), .STATUS_REG(30)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  function automatic xin_t mkx(logic v, logic [31:0] r, logic [31:0] s,
                               logic [4:0] rd, logic we, logic st, logic ld,
                               logic ovf, logic [2:0] code, logic stl, logic fl);
    xin_t x;
    x = {v, r, s, rd, we, st, ld, ovf, code, stl, fl};
    return x;
  endfunction

  function automatic exp_t mke(logic v, logic [31:0] r, logic [31:0] s,
                               logic [4:0] rd, logic we, logic st, logic ld,
                               logic exc, logic [15:0] cnt);
    exp_t e;
    e = {v, r, s, rd, we, st, ld, exc, cnt};
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t e;
    e = {bus.m_valid, bus.m_result, bus.m_store_data, bus.m_rd, bus.m_we,
         bus.m_is_store, bus.m_is_load, bus.m_exc, bus.exc_count};
    return e;
  endfunction

  task automatic drive(input xin_t x);
    bus.x_valid      = x.valid;
    bus.x_result     = x.result;
    bus.x_store_data = x.store;
    bus.x_rd         = x.rd;
    bus.x_we         = x.we;
    bus.x_is_store   = x.is_store;
    bus.x_is_load    = x.is_load;
    bus.x_ovf        = x.ovf;
    bus.x_exc_code   = x.code;
    bus.stall        = x.stall;
    bus.flush        = x.flush;
  endtask

  // One edge: apply inputs, let the DUT capture, queue the expected M state.
  task automatic step(input xin_t x, input exp_t e, input bit chk);
    drive(x);
    @(posedge clk);
    if (chk) q.push_back(e);
    #1;
  endtask

  task automatic check_now(input string name, input exp_t e);
    exp_t got;
    got = sample();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, e);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t got;
      e = q.pop_front();
      got = sample();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL mon t=%0t got v=%b r=%h s=%h rd=%0d we=%b st=%b ld=%b exc=%b cnt=%h required v=%b r=%h s=%h rd=%0d we=%b st=%b ld=%b exc=%b cnt=%h",
                 $time, got.valid, got.result, got.store, got.rd, got.we, got.is_store,
                 got.is_load, got.exc, got.cnt, e.valid, e.result, e.store, e.rd, e.we,
                 e.is_store, e.is_load, e.exc, e.cnt);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    xin_t a, b, exc_add;
    exp_t ea, z0, z1;
    z0 = '0;
    drive(mkx(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_now("reset_initial", z0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through of an SRA result.
    step(mkx(1, 32'hFFFF_FFF0, 32'h0000_1234, 7, 1, 0, 0, 0, 0, 0, 0),
         mke(1, 32'hFFFF_FFF0, 32'h0000_1234, 7, 1, 0, 0, 0, 16'd0), 1);
    // add overflow -> status register gets code 1.
    exc_add = mkx(1, 32'h8000_0000, 32'h0, 4, 1, 0, 0, 1, 3'd1, 0, 0);
    step(exc_add, mke(1, 32'd1, 32'h0, 30, 1, 0, 0, 1, 16'd1), 1);
    // Shift with spurious ovf: ordinary capture.
    step(mkx(1, 32'h0000_0040, 32'h0000_0003, 9, 1, 0, 0, 1, 3'd0, 0, 0),
         mke(1, 32'h0000_0040, 32'h0000_0003, 9, 1, 0, 0, 0, 16'd1), 1);
    // Zero destination never writes.
    step(mkx(1, 32'h0000_0077, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0),
         mke(1, 32'h0000_0077, 32'h0, 0, 0, 0, 0, 0, 16'd1), 1);
    // Load flag passes through.
    step(mkx(1, 32'h0000_1000, 32'h0, 12, 1, 0, 1, 0, 0, 0, 0),
         mke(1, 32'h0000_1000, 32'h0, 12, 1, 0, 1, 0, 16'd1), 1);
    // Bubble carrying a store flag and an exception is fully zeroed.
    step(mkx(0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5, 1, 1, 0, 1, 3'd3, 0, 0),
         mke(0, 0, 0, 0, 0, 0, 0, 0, 16'd1), 1);
    // Overflowing sub with is_load set: flags dropped, code 3.
    step(mkx(1, 32'h7FFF_FFFF, 32'h0, 8, 1, 0, 1, 1, 3'd3, 0, 0),
         mke(1, 32'd3, 32'h0, 30, 1, 0, 0, 1, 16'd2), 1);

    // Stall/flush sequence: A is a store, B an excepting mul.
    a  = mkx(1, 32'h0000_AAAA, 32'h0000_0055, 3, 0, 1, 0, 0, 0, 0, 0);
    ea = mke(1, 32'h0000_AAAA, 32'h0000_0055, 3, 0, 1, 0, 0, 16'd2);
    b  = mkx(1, 32'h1111_2222, 32'h0000_0009, 6, 1, 0, 0, 1, 3'd4, 1, 0);
    step(a, ea, 1);
    for (int i = 0; i < 3; i++) step(b, ea, 1);
    b.flush = 1'b1;
    step(b, ea, 1);
    b.stall = 1'b0;
    z1 = mke(0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
    step(b, z1, 1);

    // Reset mid-cycle while holding data and stalled.
    step(exc_add, mke(1, 32'd1, 32'h0, 30, 1, 0, 0, 1, 16'd3), 1);
    @(negedge clk); #1;
    b.flush = 1'b0;
    b.stall = 1'b1;
    drive(b);
    reset_n = 1'b0;
    #1;
    check_now("reset_async", z0);
    @(posedge clk); #1;
    check_now("reset_held", z0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    step(mkx(1, 32'h0000_0005, 32'h0000_0006, 2, 1, 0, 0, 0, 0, 0, 0),
         mke(1, 32'h0000_0005, 32'h0000_0006, 2, 1, 0, 0, 0, 16'd0), 1);

    // Saturation: 0xFFFE unchecked exceptions, then 3 checked ones.
    for (int i = 0; i < 16'hFFFE; i++) step(exc_add, z0, 0);
    for (int i = 0; i < 3; i++)
      step(exc_add, mke(1, 32'd1, 32'h0, 30, 1, 0, 0, 1, 16'hFFFF), 1);
    step(mkx(1, 32'h0000_0010, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0),
         mke(1, 32'h0000_0010, 32'h0, 1, 1, 0, 0, 0, 16'hFFFF), 1);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
